// File: rtl/host_cmd_dispatch.sv
// Host command dispatcher: runs housekeeping commands locally and forwards
// slot read/write requests to a slot agent under a cycle-count timeout.
module host_cmd_dispatch #(
    parameter logic [23:0] TIMEOUT_CYCLES   = 24'd10_000_000,
    parameter logic [15:0] CORE_VERSION     = 16'h0001,
    parameter logic        RESET_ON_POWERUP = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    input  logic [15:0]  cmd_word,
    input  logic [127:0] cmd_param,
    output logic         cmd_ack,
    output logic [15:0]  cmd_progress,
    output logic         cmd_done,
    output logic [15:0]  cmd_result,
    output logic [127:0] cmd_response,
    input  logic [15:0]  status_word,
    output logic         core_reset,
    output logic         slot_req_valid,
    output logic         slot_req_write,
    output logic [15:0]  slot_id,
    output logic [31:0]  slot_offset,
    output logic [31:0]  slot_length,
    input  logic         slot_req_ack,
    input  logic         slot_done,
    input  logic [15:0]  slot_result
);
    localparam logic [15:0] CMD_STATUS  = 16'h0000;
    localparam logic [15:0] CMD_RST_ENT = 16'h0010;
    localparam logic [15:0] CMD_RST_EXT = 16'h0011;
    localparam logic [15:0] CMD_SLOT_RD = 16'h0080;
    localparam logic [15:0] CMD_SLOT_WR = 16'h0082;
    localparam logic [15:0] RES_OK      = 16'h0000;
    localparam logic [15:0] RES_UNSUP   = 16'h0001;
    localparam logic [15:0] RES_TIMEOUT = 16'h0003;

    typedef enum logic [2:0] {IDLE, EXEC, SLOT_REQ, SLOT_WAIT, DONE} state_t;

    state_t        state;
    logic [15:0]   word_q;
    logic [79:0]   param_q;   // only the slot id/offset/length words are ever used
    logic [23:0]   cnt;
    logic          expired;
    logic          unused_param;

    assign unused_param = ^{cmd_param[127:112], cmd_param[31:0]};
    assign expired      = (cnt == TIMEOUT_CYCLES - 24'd1);
    assign cmd_ack      = (state == IDLE) && cmd_valid;
    assign cmd_progress = (state == SLOT_REQ || state == SLOT_WAIT) ? cnt[23:8] : 16'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            word_q         <= '0;
            param_q        <= '0;
            cnt            <= '0;
            cmd_done       <= 1'b0;
            cmd_result     <= '0;
            cmd_response   <= '0;
            core_reset     <= RESET_ON_POWERUP;
            slot_req_valid <= 1'b0;
            slot_req_write <= 1'b0;
            slot_id        <= '0;
            slot_offset    <= '0;
            slot_length    <= '0;
        end else begin
            // saturating: a stuck agent must not wrap the progress reading
            if ((state == SLOT_REQ || state == SLOT_WAIT) && cnt != 24'hFF_FFFF)
                cnt <= cnt + 24'd1;
            case (state)
                IDLE: if (cmd_valid) begin
                    word_q  <= cmd_word;
                    param_q <= cmd_param[111:32];
                    state   <= EXEC;
                end
                EXEC: begin
                    cnt          <= '0;
                    cmd_response <= '0;
                    cmd_result   <= RES_OK;
                    cmd_done     <= 1'b1;
                    state        <= DONE;
                    case (word_q)
                        CMD_STATUS:  cmd_response <= {CORE_VERSION, status_word, 96'h0};
                        CMD_RST_ENT: core_reset <= 1'b1;
                        CMD_RST_EXT: core_reset <= 1'b0;
                        CMD_SLOT_RD, CMD_SLOT_WR: begin
                            cmd_result     <= cmd_result;
                            cmd_response   <= cmd_response;
                            cmd_done       <= 1'b0;
                            state          <= SLOT_REQ;
                            slot_req_valid <= 1'b1;
                            slot_req_write <= (word_q == CMD_SLOT_WR);
                            slot_id        <= param_q[79:64];
                            slot_offset    <= param_q[63:32];
                            slot_length    <= param_q[31:0];
                        end
                        default:     cmd_result <= RES_UNSUP;
                    endcase
                end
                SLOT_REQ: begin
                    // expiry beats a late ack so the request cannot outlive the window
                    if (expired) begin
                        slot_req_valid <= 1'b0;
                        cmd_result     <= RES_TIMEOUT;
                        cmd_response   <= {slot_id, 112'h0};
                        cmd_done       <= 1'b1;
                        state          <= DONE;
                    end else if (slot_req_ack) begin
                        slot_req_valid <= 1'b0;
                        state          <= SLOT_WAIT;
                    end
                end
                SLOT_WAIT: begin
                    if (slot_done || expired) begin
                        cmd_result   <= slot_done ? slot_result : RES_TIMEOUT;
                        cmd_response <= {slot_id, 112'h0};
                        cmd_done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    cmd_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_host_cmd_dispatch.sv
// Scoreboard bench for host_cmd_dispatch: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever cmd_done is seen.
module tb_host_cmd_dispatch;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [15:0]  cmd_word = '0;
    logic [127:0] cmd_param = '0;
    logic         cmd_ack;
    logic [15:0]  cmd_progress;
    logic         cmd_done;
    logic [15:0]  cmd_result;
    logic [127:0] cmd_response;
    logic [15:0]  status_word = '0;
    logic         core_reset;
    logic         slot_req_valid, slot_req_write;
    logic [15:0]  slot_id;
    logic [31:0]  slot_offset, slot_length;
    logic         slot_req_ack = 1'b0;
    logic         slot_done = 1'b0;
    logic [15:0]  slot_result = '0;

    host_cmd_dispatch #(.TIMEOUT_CYCLES(24'd1000)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .cmd_param(cmd_param), .cmd_ack(cmd_ack), .cmd_progress(cmd_progress),
        .cmd_done(cmd_done), .cmd_result(cmd_result), .cmd_response(cmd_response),
        .status_word(status_word), .core_reset(core_reset),
        .slot_req_valid(slot_req_valid), .slot_req_write(slot_req_write),
        .slot_id(slot_id), .slot_offset(slot_offset), .slot_length(slot_length),
        .slot_req_ack(slot_req_ack), .slot_done(slot_done), .slot_result(slot_result)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic core_model = 1'b1;

    typedef struct {
        logic [15:0]  res;
        logic [127:0] resp;
        logic         crst;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result %0h expected no completion (cycle %0d)",
                         cmd_result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {112'h0, cmd_result}, {112'h0, mon_e.res});
                chk("response", cmd_response, mon_e.resp);
                chk("core_reset", {127'h0, core_reset}, {127'h0, mon_e.crst});
            end
        end
    end

    task automatic to_cycle(input longint n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    // DUT is always idle when this is called, so ack must come in the same cycle
    task automatic issue(input logic [15:0] w, input logic [127:0] p, input bit chain,
                         output longint t);
        @(posedge clk); #1;
        cmd_word  = w;
        cmd_param = p;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("ack_same_cycle", {127'h0, cmd_ack}, 128'h1);
        t = cyc;
        @(posedge clk); #1;
        if (chain) begin
            cmd_word  = 16'h0000;
            cmd_param = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic expect_done(input longint exp_c, input string name);
        longint dc;
        dc = -1;
        for (int i = 0; i < 1200 && dc < 0; i++) begin
            @(negedge clk);
            if (cmd_done) dc = cyc;
        end
        chk(name, dc, exp_c);
    endtask

    function automatic exp_t status_exp();
        exp_t e;
        e.res  = 16'h0000;
        e.resp = {16'h0001, status_word, 96'h0};
        e.crst = core_model;
        return e;
    endfunction

    task automatic run_local(input logic [15:0] w, input logic [127:0] p);
        exp_t e;
        longint t;
        if (w == 16'h0010) core_model = 1'b1;
        if (w == 16'h0011) core_model = 1'b0;
        e.res  = (w == 16'h0000 || w == 16'h0010 || w == 16'h0011) ? 16'h0000 : 16'h0001;
        e.resp = (w == 16'h0000) ? {16'h0001, status_word, 96'h0} : 128'h0;
        e.crst = core_model;
        if (w == 16'h0000) e = status_exp();
        sb.push_back(e);
        issue(w, p, 1'b0, t);
        expect_done(t + 2, "local_latency");
    endtask

    // ack_d / done_d count cycles after the request rises / after the ack; 0 = never.
    // The request window is 1000 cycles: done must land within 999 cycles of the request.
    task automatic run_slot(input logic [15:0] w, input logic [127:0] p, input int ack_d,
                            input int done_d, input logic [15:0] res, input bit chain);
        exp_t   e;
        longint t, r, exp_d, dc;
        int     early;
        bit     ok;
        ok = ack_d > 0 && ack_d <= 998 && done_d > 0 && ack_d + done_d <= 999;
        e.res  = ok ? res : 16'h0003;
        e.resp = {p[111:96], 112'h0};
        e.crst = core_model;
        sb.push_back(e);
        issue(w, p, chain, t);
        if (chain) sb.push_back(status_exp());
        r = -1;
        for (int i = 0; i < 5 && r < 0; i++) begin
            @(negedge clk);
            if (slot_req_valid) r = cyc;
        end
        chk("req_cycle", r, t + 2);
        chk("slot_id", {112'h0, slot_id}, {112'h0, p[111:96]});
        chk("slot_offset", {96'h0, slot_offset}, {96'h0, p[95:64]});
        chk("slot_length", {96'h0, slot_length}, {96'h0, p[63:32]});
        chk("slot_write", {127'h0, slot_req_write}, {127'h0, (w == 16'h0082)});
        exp_d = ok ? r + ack_d + done_d + 1 : r + 1000;
        dc = -1;
        early = 0;
        for (longint c = r + 1; c <= exp_d + 2 && dc < 0; c++) begin
            to_cycle(c);
            slot_req_ack = (ack_d > 0 && ack_d <= 998 && c == r + ack_d);
            // a done pulse while the request is still pending must be ignored
            slot_done    = (ok && c == r + ack_d + done_d) || (ack_d == 0 && c == r + 5);
            slot_result  = res;
            @(negedge clk);
            if (cmd_ack) early++;
            if (!ok && c == r + 900) chk("progress_900", {112'h0, cmd_progress}, 128'h3);
            if (cmd_done) begin
                dc = c;
                chk("req_dropped", {127'h0, slot_req_valid}, 128'h0);
            end
        end
        slot_req_ack = 1'b0;
        slot_done    = 1'b0;
        chk("slot_done_cycle", dc, exp_d);
        if (chain) begin
            chk("no_ack_while_busy", early, 0);
            @(negedge clk);
            chk("ack_after_done", {127'h0, cmd_ack}, 128'h1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            expect_done(dc + 3, "chained_latency");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [127:0] p;
        logic [15:0]  w;
        longint       t;
        int           sel, a, d;

        repeat (2) @(negedge clk);
        chk("rst_core_reset", {127'h0, core_reset}, 128'h1);
        chk("rst_cmd_done", {127'h0, cmd_done}, 128'h0);
        chk("rst_result", {112'h0, cmd_result}, 128'h0);
        chk("rst_response", cmd_response, 128'h0);
        chk("rst_progress", {112'h0, cmd_progress}, 128'h0);
        chk("rst_slot_valid", {127'h0, slot_req_valid}, 128'h0);
        chk("rst_slot_fields", {slot_req_write, slot_id, slot_offset, slot_length}, 128'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_local(16'h0011, 128'h0);
        run_local(16'h0010, 128'h0);
        status_word = 16'hBEEF;
        run_local(16'h0000, 128'h0);
        run_slot(16'h0080, {32'h0000_0005, 32'h100, 32'h200, 32'h0}, 3, 50, 16'h0000, 1'b0);
        run_slot(16'h0082, {32'h0000_0009, 32'h40, 32'h80, 32'h0}, 0, 0, 16'h0077, 1'b0);
        run_local(16'h1234, 128'h0);
        run_slot(16'h0080, {$urandom, $urandom, $urandom, $urandom}, 2, 10, 16'h0042, 1'b1);
        run_slot(16'h0082, {$urandom, $urandom, $urandom, $urandom}, 1, 998, 16'h0055, 1'b0);

        // reset mid-request: request drops, no completion, block accepts afterwards
        p = {$urandom, $urandom, $urandom, $urandom};
        issue(16'h0080, p, 1'b0, t);
        to_cycle(t + 4);
        slot_req_ack = 1'b1;
        to_cycle(t + 5);
        slot_req_ack = 1'b0;
        to_cycle(t + 8);
        reset_n = 1'b0;
        core_model = 1'b1;
        @(negedge clk);
        chk("abort_slot_valid", {127'h0, slot_req_valid}, 128'h0);
        chk("abort_progress", {112'h0, cmd_progress}, 128'h0);
        chk("abort_core_reset", {127'h0, core_reset}, 128'h1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        to_cycle(cyc + 20);
        run_local(16'h0011, 128'h0);

        for (int k = 0; k < 40; k++) begin
            status_word = 16'($urandom);
            p = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 9);
            case (sel)
                0: run_local(16'h0000, p);
                1: run_local(16'h0010, p);
                2: run_local(16'h0011, p);
                3: begin
                    w = 16'($urandom);
                    if (w == 16'h0000 || w == 16'h0010 || w == 16'h0011 ||
                        w == 16'h0080 || w == 16'h0082) w = 16'hFFFF;
                    run_local(w, p);
                end
                default: begin
                    a = $urandom_range(1, 6);
                    d = $urandom_range(1, 80);
                    if ($urandom_range(0, 24) == 0) a = 0;
                    if ($urandom_range(0, 24) == 0) d = 0;
                    run_slot(sel[0] ? 16'h0080 : 16'h0082, p, a, d, 16'($urandom),
                             $urandom_range(0, 4) == 0);
                end
            endcase
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
